// File: rtl/conv_pkg.sv
// Shared definitions for the convolution controllers and the multiplier pool allocator.
package conv_pkg;

    localparam int NMULT_DEF = 64;
    localparam int CW_DEF    = $clog2(NMULT_DEF + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } alloc_state_t;

endpackage

// File: rtl/mult_pool_alloc_if.sv
// Allocation/release handshake and pool-state bundle between conv controllers and the allocator.
interface mult_pool_alloc_if #(
    parameter int NMULT = conv_pkg::NMULT_DEF,
    parameter int CW    = $clog2(NMULT + 1)
);

    logic             alloc_req;
    logic [CW-1:0]    alloc_cnt;
    logic             alloc_partial;
    logic             alloc_ready;
    logic             alloc_done;
    logic [NMULT-1:0] alloc_mask;
    logic [CW-1:0]    alloc_granted;
    logic             alloc_err;
    logic             rel_valid;
    logic [NMULT-1:0] rel_mask;
    logic [NMULT-1:0] mult_map;
    logic [CW-1:0]    free_cnt;

    modport master (
        output alloc_req, alloc_cnt, alloc_partial, rel_valid, rel_mask,
        input  alloc_ready, alloc_done, alloc_mask, alloc_granted, alloc_err,
        input  mult_map, free_cnt
    );

    modport slave (
        input  alloc_req, alloc_cnt, alloc_partial, rel_valid, rel_mask,
        output alloc_ready, alloc_done, alloc_mask, alloc_granted, alloc_err,
        output mult_map, free_cnt
    );

endinterface

// File: rtl/mult_popcount.sv
// Combinational population count of an NMULT-bit vector.
module mult_popcount #(
    parameter int NMULT = conv_pkg::NMULT_DEF,
    parameter int CW    = $clog2(NMULT + 1)
) (
    input  logic [NMULT-1:0] i_vec,
    output logic [CW-1:0]    o_cnt
);

    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < NMULT; i++) begin
            o_cnt = o_cnt + CW'(i_vec[i]);
        end
    end

endmodule

// File: rtl/mult_pool_alloc.sv
// Multiplier pool allocator: owns the occupancy map, claims one scanned slot per cycle, frees on release.
// Define MULT_ALLOC_RR_EN to keep the scan pointer across requests (round-robin) instead of restarting at slot 0.
module mult_pool_alloc #(
    parameter int NMULT = conv_pkg::NMULT_DEF,
    parameter int CW    = $clog2(NMULT + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    mult_pool_alloc_if.slave bus
);
    import conv_pkg::*;

    localparam int              PW      = (NMULT > 1) ? $clog2(NMULT) : 1;
    localparam logic [CW-1:0]   NMULT_C = CW'(NMULT);
    localparam logic [NMULT-1:0] ONE    = NMULT'(1);

    alloc_state_t     r_state;
    logic             r_ready;
    logic             r_done;
    logic             r_err;
    logic             r_partial;
    logic [NMULT-1:0] r_map;
    logic [NMULT-1:0] r_work;
    logic [NMULT-1:0] r_mask;
    logic [CW-1:0]    r_free;
    logic [CW-1:0]    r_granted;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    r_target;
    logic [CW-1:0]    r_claimed;
    logic [CW-1:0]    r_examined;
    logic [PW-1:0]    r_ptr;

    logic [NMULT-1:0] w_rel_eff;
    logic [CW-1:0]    w_rel_cnt;
    logic             w_claim;
    logic [NMULT-1:0] w_claim_vec;
    logic [CW-1:0]    w_claimed_nxt;
    logic [PW-1:0]    w_ptr_nxt;

    // Only occupied bits count as released, so free_cnt never double-counts a free slot.
    assign w_rel_eff     = bus.rel_valid ? (bus.rel_mask & r_map) : '0;
    assign w_claim       = (r_state == SCAN) && !r_map[r_ptr];
    assign w_claim_vec   = w_claim ? (ONE << r_ptr) : '0;
    assign w_claimed_nxt = r_claimed + CW'(w_claim);
    assign w_ptr_nxt     = (r_ptr == PW'(NMULT - 1)) ? '0 : r_ptr + PW'(1);

    mult_popcount #(.NMULT(NMULT), .CW(CW)) u_rel_pop (
        .i_vec (w_rel_eff),
        .o_cnt (w_rel_cnt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_map  <= '0;
            r_free <= NMULT_C;
        end else begin
            r_map  <= (r_map & ~w_rel_eff) | w_claim_vec;
            r_free <= r_free + w_rel_cnt - CW'(w_claim);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_partial  <= 1'b0;
            r_work     <= '0;
            r_mask     <= '0;
            r_granted  <= '0;
            r_cnt      <= '0;
            r_target   <= '0;
            r_claimed  <= '0;
            r_examined <= '0;
            r_ptr      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.alloc_req) begin
                        r_cnt     <= bus.alloc_cnt;
                        r_partial <= bus.alloc_partial;
                        r_work    <= '0;
                        r_ready   <= 1'b0;
                        r_state   <= CHECK;
                    end
                end
                CHECK: begin
                    if (r_cnt == '0 || r_cnt > NMULT_C ||
                        (r_free < r_cnt && r_partial && r_free == '0)) begin
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_mask    <= '0;
                        r_granted <= '0;
                        r_err     <= (r_cnt > NMULT_C);
                    end else if (r_free >= r_cnt || r_partial) begin
                        r_target   <= (r_free >= r_cnt) ? r_cnt : r_free;
                        r_claimed  <= '0;
                        r_examined <= '0;
`ifndef MULT_ALLOC_RR_EN
                        r_ptr      <= '0;
`endif
                        r_state    <= SCAN;
                    end
                end
                SCAN: begin
                    r_work     <= r_work | w_claim_vec;
                    r_claimed  <= w_claimed_nxt;
                    r_examined <= r_examined + CW'(1);
                    r_ptr      <= w_ptr_nxt;
                    // Releases behind the pointer are not revisited; a full lap ends the request.
                    if (w_claimed_nxt == r_target || r_examined == NMULT_C - CW'(1)) begin
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_mask    <= r_work | w_claim_vec;
                        r_granted <= w_claimed_nxt;
                        r_err     <= 1'b0;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.alloc_ready   = r_ready;
    assign bus.alloc_done    = r_done;
    assign bus.alloc_mask    = r_mask;
    assign bus.alloc_granted = r_granted;
    assign bus.alloc_err     = r_err;
    assign bus.mult_map      = r_map;
    assign bus.free_cnt      = r_free;

endmodule

// File: tb/tb_mult_pool_alloc.sv
// Directed, table-driven bench for mult_pool_alloc plus multi-cycle corner sequences.
module tb_mult_pool_alloc;

    localparam int NMULT = 64;
    localparam int CW    = 7;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_bad;

    mult_pool_alloc_if #(.NMULT(NMULT), .CW(CW)) ifc ();

    mult_pool_alloc #(.NMULT(NMULT), .CW(CW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rel;
        int          cnt;
        bit          partial;
        logic [63:0] mask;
        int          granted;
        bit          err;
        int          free;
        logic [63:0] map;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic rel(input logic [63:0] m);
        ifc.rel_valid = 1'b1;
        ifc.rel_mask  = m;
        @(negedge clk);
        ifc.rel_valid = 1'b0;
        ifc.rel_mask  = '0;
    endtask

    task automatic issue(input int cnt, input bit partial);
        int w;
        w = 0;
        while (!ifc.alloc_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        ifc.alloc_req     = 1'b1;
        ifc.alloc_cnt     = CW'(cnt);
        ifc.alloc_partial = partial;
        @(negedge clk);
        ifc.alloc_req     = 1'b0;
    endtask

    // Returns at the negedge where alloc_done is seen; lat counts cycles after the accepting edge.
    task automatic run_alloc(input int cnt, input bit partial, output int lat);
        issue(cnt, partial);
        lat = 1;
        while (!ifc.alloc_done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!ifc.alloc_done) lat = -1;
    endtask

    task automatic wait_done(input string name);
        int w;
        w = 0;
        while (!ifc.alloc_done && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk(name, 64'(ifc.alloc_done), 64'd1);
    endtask

    initial begin
        int  lat;
        int  n;
        bit  seen;

        n_cmp = 0;
        n_bad = 0;
        rstn  = 1'b0;
        ifc.alloc_req     = 1'b0;
        ifc.alloc_cnt     = '0;
        ifc.alloc_partial = 1'b0;
        ifc.rel_valid     = 1'b0;
        ifc.rel_mask      = '0;

        vecs[0] = '{64'h0, 10, 1'b0, 64'h3FF, 10, 1'b0, 54, 64'h3FF, 12};
        vecs[1] = '{64'h0, 0, 1'b0, 64'h0, 0, 1'b0, 54, 64'h3FF, 2};
        vecs[2] = '{64'h0, 65, 1'b0, 64'h0, 0, 1'b1, 54, 64'h3FF, 2};
`ifdef MULT_ALLOC_RR_EN
        vecs[3] = '{64'h0, 54, 1'b0, 64'hFFFF_FFFF_FFFF_FC00, 54, 1'b0, 0, ALL1, 56};
        vecs[5] = '{64'h3FF, 3, 1'b0, 64'h7, 3, 1'b0, 7, 64'hFFFF_FFFF_FFFF_FC07, 59};
        vecs[6] = '{64'h0, 8, 1'b1, 64'h3F8, 7, 1'b0, 0, ALL1, 9};
`else
        vecs[3] = '{64'h0, 54, 1'b0, 64'hFFFF_FFFF_FFFF_FC00, 54, 1'b0, 0, ALL1, 66};
        vecs[5] = '{64'h3FF, 3, 1'b0, 64'h7, 3, 1'b0, 7, 64'hFFFF_FFFF_FFFF_FC07, 5};
        vecs[6] = '{64'h0, 8, 1'b1, 64'h3F8, 7, 1'b0, 0, ALL1, 12};
`endif
        vecs[4] = '{64'h220, 4, 1'b1, 64'h220, 2, 1'b0, 0, ALL1, 12};
        vecs[7] = '{64'h0, 1, 1'b1, 64'h0, 0, 1'b0, 0, ALL1, 2};
        vecs[8] = '{ALL1, 64, 1'b0, ALL1, 64, 1'b0, 0, ALL1, 66};

        do_reset();
        chk("rst_ready",   64'(ifc.alloc_ready),   64'd1);
        chk("rst_done",    64'(ifc.alloc_done),    64'd0);
        chk("rst_mask",    ifc.alloc_mask,         64'd0);
        chk("rst_granted", 64'(ifc.alloc_granted), 64'd0);
        chk("rst_err",     64'(ifc.alloc_err),     64'd0);
        chk("rst_map",     ifc.mult_map,           64'd0);
        chk("rst_free",    64'(ifc.free_cnt),      64'd64);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].rel != 64'h0) rel(vecs[i].rel);
            run_alloc(vecs[i].cnt, vecs[i].partial, lat);
            chk($sformatf("v%0d_lat", i),     64'(lat),               64'(vecs[i].lat));
            chk($sformatf("v%0d_mask", i),    ifc.alloc_mask,         vecs[i].mask);
            chk($sformatf("v%0d_granted", i), 64'(ifc.alloc_granted), 64'(vecs[i].granted));
            chk($sformatf("v%0d_err", i),     64'(ifc.alloc_err),     64'(vecs[i].err));
            chk($sformatf("v%0d_free", i),    64'(ifc.free_cnt),      64'(vecs[i].free));
            chk($sformatf("v%0d_map", i),     ifc.mult_map,           vecs[i].map);
            @(negedge clk);
            chk($sformatf("v%0d_pulse", i),   64'(ifc.alloc_done),    64'd0);
            chk($sformatf("v%0d_hold", i),    ifc.alloc_mask,         vecs[i].mask);
        end

        // Short pool without partial: must wait in CHECK until a release covers the request.
        rel(64'h220);
        issue(4, 1'b0);
        seen = 1'b0;
        repeat (6) begin
            seen = seen | ifc.alloc_done;
            @(negedge clk);
        end
        chk("wait_no_done", 64'(seen),              64'd0);
        chk("wait_busy",    64'(ifc.alloc_ready),   64'd0);
        chk("wait_free",    64'(ifc.free_cnt),      64'd2);
        rel(64'hF);
        wait_done("wait_done");
        chk("wait_mask",    ifc.alloc_mask,         64'hF);
        chk("wait_granted", 64'(ifc.alloc_granted), 64'd4);
        chk("wait_free2",   64'(ifc.free_cnt),      64'd2);
        chk("wait_map",     ifc.mult_map,           ~64'h220);

        // Release of bits 0-7 while a 20-slot request is scanning.
        do_reset();
        run_alloc(8, 1'b0, lat);
        chk("pre_mask", ifc.alloc_mask, 64'hFF);
        @(negedge clk);
        issue(20, 1'b0);
        n = 1;
        while (!ifc.alloc_done && n < 200) begin
            chk($sformatf("inv_free_c%0d", n), 64'(ifc.free_cnt), 64'(64 - $countones(ifc.mult_map)));
            ifc.rel_valid = (n == 3);
            ifc.rel_mask  = (n == 3) ? 64'hFF : 64'h0;
            @(negedge clk);
            n++;
        end
        ifc.rel_valid = 1'b0;
        ifc.rel_mask  = '0;
`ifdef MULT_ALLOC_RR_EN
        chk("rs_lat",  64'(n),          64'd22);
        chk("rs_mask", ifc.alloc_mask,  64'hFFF_FF00);
        chk("rs_map",  ifc.mult_map,    64'hFFF_FF00);
`else
        chk("rs_lat",  64'(n),          64'd24);
        chk("rs_mask", ifc.alloc_mask,  64'h3F_FFFC);
        chk("rs_map",  ifc.mult_map,    64'h3F_FFFC);
`endif
        chk("rs_granted", 64'(ifc.alloc_granted), 64'd20);
        chk("rs_free",    64'(ifc.free_cnt),      64'd44);

        // Reset in the middle of a scan.
        @(negedge clk);
        issue(30, 1'b0);
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mid_rst_map",   ifc.mult_map,          64'd0);
        chk("mid_rst_free",  64'(ifc.free_cnt),     64'd64);
        chk("mid_rst_ready", 64'(ifc.alloc_ready),  64'd1);
        chk("mid_rst_done",  64'(ifc.alloc_done),   64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        run_alloc(4, 1'b0, lat);
        chk("seq4a_mask", ifc.alloc_mask, 64'hF);
        run_alloc(4, 1'b0, lat);
        chk("seq4b_mask", ifc.alloc_mask, 64'hF0);
        rel(64'hFF);
        run_alloc(4, 1'b0, lat);
`ifdef MULT_ALLOC_RR_EN
        chk("seq4c_mask", ifc.alloc_mask, 64'hF00);
`else
        chk("seq4c_mask", ifc.alloc_mask, 64'hF);
`endif
        chk("seq4c_free", 64'(ifc.free_cnt), 64'd60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
